// File: rtl/sort_net_pipe.sv
// Pipelined odd-even transposition sorter: N compare stages between N+1 register banks,
// stable on equal keys, per-beat ascending/descending order, global-stall valid/ready flow.

module sort_net_cx #(
    parameter int W  = 32,
    parameter int IW = 4
) (
    input  logic          desc,
    input  logic [W-1:0]  a_key,
    input  logic [IW-1:0] a_idx,
    input  logic [W-1:0]  b_key,
    input  logic [IW-1:0] b_idx,
    output logic [W-1:0]  lo_key,
    output logic [IW-1:0] lo_idx,
    output logic [W-1:0]  hi_key,
    output logic [IW-1:0] hi_idx
);
    logic swap;

    // Strict compare: equal keys stay put, which keeps the sort stable.
    assign swap   = desc ? (a_key < b_key) : (a_key > b_key);
    assign lo_key = swap ? b_key : a_key;
    assign lo_idx = swap ? b_idx : a_idx;
    assign hi_key = swap ? a_key : b_key;
    assign hi_idx = swap ? a_idx : b_idx;
endmodule

module sort_net_pipe #(
    parameter int N  = 10,
    parameter int W  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_desc,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_desc,
    output logic [N*W-1:0]  out_data,
    output logic [N*IW-1:0] out_idx
);
    // Bank 0 holds the raw accepted vector; stage s sorts bank s into bank s+1.
    logic [N:0]           vld_pipe;
    logic [N:0]           desc_pipe;
    logic [N-1:0][W-1:0]  key_q [N+1];
    logic [N-1:0][IW-1:0] idx_q [N+1];
    logic [N-1:0][W-1:0]  key_d [N];
    logic [N-1:0][IW-1:0] idx_d [N];
    logic [N-1:0][W-1:0]  in_key;
    logic [N-1:0][IW-1:0] in_idx;
    logic                 advance;

    assign advance   = !vld_pipe[N] || out_ready;
    assign in_ready  = rst_n && advance;
    assign in_key    = in_data;
    assign out_valid = vld_pipe[N];
    assign out_desc  = desc_pipe[N];
    assign out_data  = key_q[N];
    assign out_idx   = idx_q[N];

    for (genvar i = 0; i < N; i++) begin : g_idx
        assign in_idx[i] = IW'(i);
    end

    for (genvar s = 0; s < N; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_elem
            if ((i % 2 == s % 2) && (i + 1 < N)) begin : g_cx
                sort_net_cx #(.W(W), .IW(IW)) u_cx (
                    .desc   (desc_pipe[s]),
                    .a_key  (key_q[s][i]),
                    .a_idx  (idx_q[s][i]),
                    .b_key  (key_q[s][i+1]),
                    .b_idx  (idx_q[s][i+1]),
                    .lo_key (key_d[s][i]),
                    .lo_idx (idx_d[s][i]),
                    .hi_key (key_d[s][i+1]),
                    .hi_idx (idx_d[s][i+1])
                );
            end else if (!((i > 0) && ((i - 1) % 2 == s % 2))) begin : g_pass
                // Edge element with no partner in this phase.
                assign key_d[s][i] = key_q[s][i];
                assign idx_d[s][i] = idx_q[s][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            desc_pipe <= '0;
            for (int s = 0; s <= N; s++) begin
                key_q[s] <= '0;
                idx_q[s] <= '0;
            end
        end else if (advance) begin
            vld_pipe  <= {vld_pipe[N-1:0], in_valid};
            desc_pipe <= {desc_pipe[N-1:0], in_desc};
            key_q[0]  <= in_key;
            idx_q[0]  <= in_idx;
            for (int s = 0; s < N; s++) begin
                key_q[s+1] <= key_d[s];
                idx_q[s+1] <= idx_d[s];
            end
        end
    end
endmodule
